// File: rtl/iter_divider.sv
// rtl/iter_divider.sv - multi-cycle restoring unsigned divider, start/done handshake
module iter_divider #(
    parameter int WIDTH          = 64,
    parameter int BITS_PER_CYCLE = 2
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int ITER = WIDTH / BITS_PER_CYCLE;
    localparam int CW   = $clog2(ITER + 1);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FINISH
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] rem_q;
    logic [WIDTH-1:0] shreg_q;
    logic [WIDTH-1:0] div_q;
    logic [WIDTH-1:0] rem_nxt;
    logic [WIDTH-1:0] shreg_nxt;
    logic [WIDTH:0]   r_sh;
    logic [WIDTH:0]   diff;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // A zero divisor bypasses CALC entirely and completes on the next edge.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = (divisor == '0) ? FINISH : CALC;
                end
            end
            CALC: begin
                if (cnt == CW'(1)) begin
                    state_nxt = FINISH;
                end
            end
            FINISH:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign busy = (state != IDLE);

    // The partial remainder stays below the divisor, so the shifted value is
    // under 2*divisor and the top bit of the WIDTH+1-bit difference is its sign.
    always_comb begin
        rem_nxt   = rem_q;
        shreg_nxt = shreg_q;
        r_sh      = '0;
        diff      = '0;
        for (int i = 0; i < BITS_PER_CYCLE; i++) begin
            r_sh      = {rem_nxt, shreg_nxt[WIDTH-1]};
            diff      = r_sh - {1'b0, div_q};
            shreg_nxt = {shreg_nxt[WIDTH-2:0], ~diff[WIDTH]};
            rem_nxt   = diff[WIDTH] ? r_sh[WIDTH-1:0] : diff[WIDTH-1:0];
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cnt         <= '0;
            rem_q       <= '0;
            shreg_q     <= '0;
            div_q       <= '0;
            done        <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        div_q   <= divisor;
                        shreg_q <= dividend;
                        rem_q   <= '0;
                        cnt     <= (divisor == '0) ? '0 : CW'(ITER);
                    end
                end
                CALC: begin
                    rem_q   <= rem_nxt;
                    shreg_q <= shreg_nxt;
                    cnt     <= cnt - CW'(1);
                end
                FINISH: begin
                    done <= 1'b1;
                    // On a zero divisor the shift register still holds the dividend.
                    if (div_q == '0) begin
                        quotient    <= '1;
                        remainder   <= shreg_q;
                        div_by_zero <= 1'b1;
                    end else begin
                        quotient    <= shreg_q;
                        remainder   <= rem_q;
                        div_by_zero <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_iter_divider.sv
// tb/tb_iter_divider.sv - directed self-checking bench for iter_divider
module tb_iter_divider;

    localparam int W = 64;

    logic         clock = 1'b0;
    logic         reset_n;
    logic         start, start_1, start_4;
    logic [W-1:0] dividend, divisor;

    logic         busy, done, dz;
    logic [W-1:0] quotient, remainder;
    logic         busy_1, done_1, dz_1;
    logic [W-1:0] quotient_1, remainder_1;
    logic         busy_4, done_4, dz_4;
    logic [W-1:0] quotient_4, remainder_4;

    int passed = 0;
    int total  = 0;

    always #5 clock = ~clock;

    iter_divider #(.WIDTH(W), .BITS_PER_CYCLE(2)) dut (
        .clock(clock), .reset_n(reset_n), .start(start),
        .dividend(dividend), .divisor(divisor),
        .busy(busy), .done(done), .quotient(quotient),
        .remainder(remainder), .div_by_zero(dz)
    );

    iter_divider #(.WIDTH(W), .BITS_PER_CYCLE(1)) dut_1 (
        .clock(clock), .reset_n(reset_n), .start(start_1),
        .dividend(dividend), .divisor(divisor),
        .busy(busy_1), .done(done_1), .quotient(quotient_1),
        .remainder(remainder_1), .div_by_zero(dz_1)
    );

    iter_divider #(.WIDTH(W), .BITS_PER_CYCLE(4)) dut_4 (
        .clock(clock), .reset_n(reset_n), .start(start_4),
        .dividend(dividend), .divisor(divisor),
        .busy(busy_4), .done(done_4), .quotient(quotient_4),
        .remainder(remainder_4), .div_by_zero(dz_4)
    );

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Issues one request and returns the number of edges after acceptance until done.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                          output int n, output int busy_low);
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        step();
        start    = 1'b0;
        n        = 0;
        busy_low = 0;
        while (done !== 1'b1 && n < 200) begin
            if (busy !== 1'b1) busy_low++;
            step();
            n++;
        end
    endtask

    initial begin
        int n, bl, ndone, first, first_1, first_4;

        reset_n  = 1'b0;
        start    = 1'b0;
        start_1  = 1'b0;
        start_4  = 1'b0;
        dividend = '0;
        divisor  = '0;
        step();
        step();
        check("reset_busy", W'(busy), 64'd0);
        check("reset_done", W'(done), 64'd0);
        check("reset_quotient", quotient, 64'd0);
        check("reset_remainder", remainder, 64'd0);
        check("reset_dz", W'(dz), 64'd0);
        reset_n = 1'b1;
        step();

        run_op(64'd100, 64'd7, n, bl);
        check("basic_latency", W'(n), 64'd33);
        check("basic_busy_gaps", W'(bl), 64'd0);
        check("basic_quotient", quotient, 64'd14);
        check("basic_remainder", remainder, 64'd2);
        check("basic_dz", W'(dz), 64'd0);
        check("basic_busy_at_done", W'(busy), 64'd0);
        step();
        check("done_single_pulse", W'(done), 64'd0);
        check("hold_quotient", quotient, 64'd14);

        run_op(64'h1234, 64'd0, n, bl);
        check("dz_latency", W'(n), 64'd1);
        check("dz_quotient", quotient, 64'hFFFF_FFFF_FFFF_FFFF);
        check("dz_remainder", remainder, 64'h1234);
        check("dz_flag", W'(dz), 64'd1);

        run_op(64'd9, 64'd3, n, bl);
        check("after_dz_latency", W'(n), 64'd33);
        check("after_dz_quotient", quotient, 64'd3);
        check("after_dz_remainder", remainder, 64'd0);
        check("after_dz_flag", W'(dz), 64'd0);

        run_op(64'hFFFF_FFFF_FFFF_FFFF, 64'd1, n, bl);
        check("ones_quotient", quotient, 64'hFFFF_FFFF_FFFF_FFFF);
        check("ones_remainder", remainder, 64'd0);

        run_op(64'd5, 64'd9, n, bl);
        check("small_latency", W'(n), 64'd33);
        check("small_quotient", quotient, 64'd0);
        check("small_remainder", remainder, 64'd5);

        run_op(64'h8000_0000_0000_0000, 64'hFFFF_FFFF, n, bl);
        check("big_quotient", quotient, 64'h8000_0000);
        check("big_remainder", remainder, 64'h8000_0000);

        // Second start while busy must be dropped.
        step();
        dividend = 64'd100;
        divisor  = 64'd7;
        start    = 1'b1;
        step();
        start    = 1'b0;
        ndone    = 0;
        first    = 0;
        for (int e = 1; e <= 80; e++) begin
            if (e == 10) begin
                dividend = 64'd50;
                divisor  = 64'd5;
                start    = 1'b1;
            end
            step();
            start = 1'b0;
            if (done === 1'b1) begin
                ndone++;
                if (first == 0) first = e;
            end
        end
        check("ignored_done_count", W'(ndone), 64'd1);
        check("ignored_latency", W'(first), 64'd33);
        check("ignored_quotient", quotient, 64'd14);
        check("ignored_remainder", remainder, 64'd2);

        // Reset in the middle of an operation.
        dividend = 64'd100;
        divisor  = 64'd7;
        start    = 1'b1;
        step();
        start    = 1'b0;
        for (int e = 1; e <= 10; e++) step();
        reset_n = 1'b0;
        #1;
        check("midrst_busy", W'(busy), 64'd0);
        check("midrst_done", W'(done), 64'd0);
        check("midrst_quotient", quotient, 64'd0);
        check("midrst_remainder", remainder, 64'd0);
        check("midrst_dz", W'(dz), 64'd0);
        #2;
        reset_n = 1'b1;
        ndone   = 0;
        for (int e = 0; e < 40; e++) begin
            step();
            if (done !== 1'b0 || busy !== 1'b0) ndone++;
        end
        check("midrst_no_done", W'(ndone), 64'd0);

        // Back-to-back: the second start lands in the done cycle of the first.
        run_op(64'd100, 64'd7, n, bl);
        check("b2b_first_quotient", quotient, 64'd14);
        run_op(64'd20, 64'd6, n, bl);
        check("b2b_second_latency", W'(n), 64'd33);
        check("b2b_second_quotient", quotient, 64'd3);
        check("b2b_second_remainder", remainder, 64'd2);
        step();

        // Same operation at 1 and 4 quotient bits per cycle.
        dividend = 64'd100;
        divisor  = 64'd7;
        start_1  = 1'b1;
        start_4  = 1'b1;
        step();
        start_1  = 1'b0;
        start_4  = 1'b0;
        first_1  = 0;
        first_4  = 0;
        for (int e = 1; e <= 80; e++) begin
            step();
            if (done_1 === 1'b1 && first_1 == 0) first_1 = e;
            if (done_4 === 1'b1 && first_4 == 0) first_4 = e;
        end
        check("bpc1_latency", W'(first_1), 64'd65);
        check("bpc1_quotient", quotient_1, 64'd14);
        check("bpc1_remainder", remainder_1, 64'd2);
        check("bpc4_latency", W'(first_4), 64'd17);
        check("bpc4_quotient", quotient_4, 64'd14);
        check("bpc4_remainder", remainder_4, 64'd2);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
